// File: rtl/regfile_pkg.sv
// Shared constants for the integer register file and its busy scoreboard.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int DATA_W_DEFAULT   = 32;
    localparam int NUM_REGS_DEFAULT = 32;
    localparam int ADDR_W_DEFAULT   = $clog2(NUM_REGS_DEFAULT);
    localparam int REG_ZERO         = 0;

    // Index width for a given register count; never narrower than one bit.
    function automatic int addr_w_of(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits tracking in-flight producers, plus a sticky double-reserve flag.
// With REGFILE_BYPASS_EN, a same-cycle write hides the busy bit on a matching read port.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEFAULT,
    parameter int ADDR_W   = addr_w_of(NUM_REGS)
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_idx,
    input  logic              reserve_en,
    input  logic [ADDR_W-1:0] reserve_idx,
    input  logic [ADDR_W-1:0] read_a_idx,
    input  logic [ADDR_W-1:0] read_b_idx,
    output logic              busy_a,
    output logic              busy_b,
    output logic              err_double_reserve
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [NUM_REGS-1:0] busy_r;
    logic [NUM_REGS-1:0] busy_next_s;
    logic                err_r;
    logic                write_hit_s;
    logic                reserve_hit_s;
    logic                same_idx_s;
    logic                double_reserve_s;

    // Next busy vector: a reserve outranks a same-edge write so the newest producer wins.
    always_comb begin
        write_hit_s      = write_en && (write_idx != ZERO_IDX);
        reserve_hit_s    = reserve_en && (reserve_idx != ZERO_IDX);
        same_idx_s       = write_hit_s && (write_idx == reserve_idx);
        double_reserve_s = reserve_hit_s && busy_r[reserve_idx] && !same_idx_s;
        busy_next_s      = busy_r;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_next_s[i] = (reserve_hit_s && (reserve_idx == ADDR_W'(i))) ? 1'b1 :
                             (write_hit_s && (write_idx == ADDR_W'(i)))     ? 1'b0 :
                             busy_r[i];
        end
        busy_next_s[REG_ZERO] = 1'b0;
    end

    // Busy bits and sticky error flag.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= '0;
            err_r  <= 1'b0;
        end else begin
            busy_r <= busy_next_s;
            err_r  <= err_r | double_reserve_s;
        end
    end

    // Busy read ports.
    always_comb begin
`ifdef REGFILE_BYPASS_EN
        busy_a = (write_hit_s && (write_idx == read_a_idx) &&
                  !(reserve_hit_s && (reserve_idx == read_a_idx))) ? 1'b0 : busy_r[read_a_idx];
        busy_b = (write_hit_s && (write_idx == read_b_idx) &&
                  !(reserve_hit_s && (reserve_idx == read_b_idx))) ? 1'b0 : busy_r[read_b_idx];
`else
        busy_a = busy_r[read_a_idx];
        busy_b = busy_r[read_b_idx];
`endif
        err_double_reserve = err_r;
    end

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write integer register file with integrated busy scoreboard; r0 reads zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int  DATA_W   = DATA_W_DEFAULT,
    parameter int  NUM_REGS = NUM_REGS_DEFAULT,
    localparam int ADDR_W   = addr_w_of(NUM_REGS)
) (
    input  logic              clock,
    input  logic              ctrl_reset_n,
    input  logic              ctrl_writeEnable,
    input  logic [ADDR_W-1:0] ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic              ctrl_reserveEnable,
    input  logic [ADDR_W-1:0] ctrl_reserveReg,
    input  logic [ADDR_W-1:0] ctrl_readRegA,
    input  logic [ADDR_W-1:0] ctrl_readRegB,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB,
    output logic              busy_readRegA,
    output logic              busy_readRegB,
    output logic              err_doubleReserve
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_r [NUM_REGS];
    logic              write_hit_s;

    assign write_hit_s = ctrl_writeEnable && (ctrl_writeReg != ZERO_IDX);

    // Architectural storage; entry 0 is never written so it holds its reset zero.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (write_hit_s) begin
            regs_r[ctrl_writeReg] <= data_writeReg;
        end
    end

    // Read muxes.
    always_comb begin
`ifdef REGFILE_BYPASS_EN
        data_readRegA = (write_hit_s && (ctrl_writeReg == ctrl_readRegA)) ? data_writeReg
                                                                          : regs_r[ctrl_readRegA];
        data_readRegB = (write_hit_s && (ctrl_writeReg == ctrl_readRegB)) ? data_writeReg
                                                                          : regs_r[ctrl_readRegB];
`else
        data_readRegA = regs_r[ctrl_readRegA];
        data_readRegB = regs_r[ctrl_readRegB];
`endif
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clock              (clock),
        .rst_n              (ctrl_reset_n),
        .write_en           (ctrl_writeEnable),
        .write_idx          (ctrl_writeReg),
        .reserve_en         (ctrl_reserveEnable),
        .reserve_idx        (ctrl_reserveReg),
        .read_a_idx         (ctrl_readRegA),
        .read_b_idx         (ctrl_readRegB),
        .busy_a             (busy_readRegA),
        .busy_b             (busy_readRegB),
        .err_double_reserve (err_doubleReserve)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed scoreboard bench for regfile_sb: default 32x32 instance plus a 16-bit x 8 instance.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        ctrl_reset_n;
    logic        we, re;
    logic [4:0]  wreg, rreg, ra, rb;
    logic [31:0] wdata;
    logic [31:0] da, db;
    logic        ba, bb, err;

    logic        we8, re8;
    logic [2:0]  wreg8, rreg8, ra8, rb8;
    logic [15:0] wdata8, da8, db8;
    logic        ba8, bb8, err8;

    always #5 clock = ~clock;

    regfile_sb dut (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n),
        .ctrl_writeEnable(we), .ctrl_writeReg(wreg), .data_writeReg(wdata),
        .ctrl_reserveEnable(re), .ctrl_reserveReg(rreg),
        .ctrl_readRegA(ra), .ctrl_readRegB(rb),
        .data_readRegA(da), .data_readRegB(db),
        .busy_readRegA(ba), .busy_readRegB(bb),
        .err_doubleReserve(err)
    );

    regfile_sb #(.DATA_W(16), .NUM_REGS(8)) dut8 (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n),
        .ctrl_writeEnable(we8), .ctrl_writeReg(wreg8), .data_writeReg(wdata8),
        .ctrl_reserveEnable(re8), .ctrl_reserveReg(rreg8),
        .ctrl_readRegA(ra8), .ctrl_readRegB(rb8),
        .data_readRegA(da8), .data_readRegB(db8),
        .busy_readRegA(ba8), .busy_readRegB(bb8),
        .err_doubleReserve(err8)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic expect_val(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL queue_underrun: observed %h expected <none>", obs);
        end else begin
            e = exp_q.pop_front();
            vectors++;
            assert (obs === e.exp) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic w, input logic [4:0] wi, input logic [31:0] wd,
                         input logic r, input logic [4:0] ri);
        we = w; wreg = wi; wdata = wd; re = r; rreg = ri;
    endtask

    task automatic look(input string tag, input logic [4:0] ia, input logic [4:0] ib,
                        input logic [31:0] ea, input logic [31:0] eb,
                        input logic eba, input logic ebb);
        ra = ia;
        rb = ib;
        expect_val({tag, "_dataA"}, ea);
        expect_val({tag, "_dataB"}, eb);
        expect_val({tag, "_busyA"}, {31'd0, eba});
        expect_val({tag, "_busyB"}, {31'd0, ebb});
        #1;
        check(da);
        check(db);
        check({31'd0, ba});
        check({31'd0, bb});
    endtask

    task automatic chk_err(input string tag, input logic e);
        expect_val(tag, {31'd0, e});
        check({31'd0, err});
    endtask

    initial begin
        ctrl_reset_n = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        ra = 5'd0; rb = 5'd0;
        we8 = 1'b0; wreg8 = 3'd0; wdata8 = 16'd0; re8 = 1'b0; rreg8 = 3'd0;
        ra8 = 3'd0; rb8 = 3'd0;
        repeat (2) tick();

        for (int i = 0; i < 32; i++) begin
            look("reset", 5'(i), 5'(31 - i), 32'd0, 32'd0, 1'b0, 1'b0);
        end
        chk_err("reset_err", 1'b0);
        ctrl_reset_n = 1'b1;
        tick();

        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0);
        look("wr5_same", 5'd5, 5'd5, BYP ? 32'hDEAD_BEEF : 32'd0,
             BYP ? 32'hDEAD_BEEF : 32'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        look("wr5", 5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);

        drive(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0);
        look("wr0_same", 5'd0, 5'd5, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
        look("wr0", 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        look("rsv0", 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk_err("rsv0_err", 1'b0);

        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        look("rsv7_same", 5'd7, 5'd7, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        look("rsv7", 5'd7, 5'd7, 32'd0, 32'd0, 1'b1, 1'b1);
        drive(1'b1, 5'd7, 32'h0000_0055, 1'b0, 5'd0);
        look("wr7_same", 5'd7, 5'd0, BYP ? 32'h55 : 32'd0, 32'd0, !BYP, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        look("wr7", 5'd7, 5'd7, 32'h0000_0055, 32'h0000_0055, 1'b0, 1'b0);
        chk_err("wr7_err", 1'b0);

        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10);
        tick();
        drive(1'b1, 5'd10, 32'h0000_AAAA, 1'b1, 5'd10);
        look("wrsv10_same", 5'd10, 5'd7, BYP ? 32'hAAAA : 32'd0, 32'h55, 1'b1, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        look("wrsv10", 5'd10, 5'd10, 32'h0000_AAAA, 32'h0000_AAAA, 1'b1, 1'b1);
        chk_err("wrsv10_err", 1'b0);

        drive(1'b1, 5'd11, 32'h0000_1111, 1'b1, 5'd12);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        look("split", 5'd11, 5'd12, 32'h0000_1111, 32'd0, 1'b0, 1'b1);

        drive(1'b1, 5'd3, 32'h0000_CAFE, 1'b0, 5'd0);
        look("byp3_same", 5'd3, 5'd0, BYP ? 32'hCAFE : 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        look("byp3", 5'd3, 5'd3, 32'h0000_CAFE, 32'h0000_CAFE, 1'b0, 1'b0);

        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        tick();
        chk_err("rsv9_first", 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk_err("rsv9_double", 1'b1);
        look("rsv9", 5'd9, 5'd9, 32'd0, 32'd0, 1'b1, 1'b1);
        tick();
        chk_err("err_sticky", 1'b1);
        drive(1'b1, 5'd9, 32'h0000_0099, 1'b1, 5'd9);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        look("wrsv9", 5'd9, 5'd9, 32'h0000_0099, 32'h0000_0099, 1'b1, 1'b1);
        chk_err("wrsv9_err", 1'b1);

        #2;
        ctrl_reset_n = 1'b0;
        #1;
        look("arst_a", 5'd5, 5'd12, 32'd0, 32'd0, 1'b0, 1'b0);
        chk_err("arst_err", 1'b0);
        look("arst_b", 5'd9, 5'd3, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 5'd5, 32'h0000_0123, 1'b1, 5'd6);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        look("rst_hold", 5'd5, 5'd6, 32'd0, 32'd0, 1'b0, 1'b0);
        ctrl_reset_n = 1'b1;
        drive(1'b1, 5'd5, 32'h0000_0077, 1'b0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        look("post_rst", 5'd5, 5'd9, 32'h0000_0077, 32'd0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            we8 = 1'b1;
            wreg8 = 3'(i);
            wdata8 = 16'h0001 << (2 * i);
            tick();
        end
        we8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ra8 = 3'(i);
            rb8 = 3'(7 - i);
            expect_val("sweep_dataA", (i == 0) ? 32'd0 : (32'h1 << (2 * i)));
            expect_val("sweep_dataB", (i == 7) ? 32'd0 : (32'h1 << (2 * (7 - i))));
            #1;
            check({16'd0, da8});
            check({16'd0, db8});
        end
        expect_val("sweep_busy", 32'd0);
        check({30'd0, ba8, bb8});
        expect_val("sweep_err", 32'd0);
        check({31'd0, err8});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
